cache_mem_arbiter: RTL and testbench

- Two-port arbiter between the instruction-cache and data-cache controllers and the single shared DRAM block interface.
- Latches each cache's one-cycle miss request, grants DRAM to one requester at a time, and holds the DRAM request stable until the DRAM acknowledges.
- Returns the block read data and a one-cycle ready pulse to the owning cache.
- Sits between both cache controllers and the DRAM model or controller.

---
 rtl/cache_mem_arbiter_if.sv | 53 +++++
 rtl/cache_mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if
// Bundles the instruction-cache, data-cache and DRAM block-interface signals
// handled by cache_mem_arbiter.
//   slave  modport : arbiter view (takes cache requests, drives DRAM request)
//   master modport : environment view (caches + DRAM model)
// Signal groups:
//   ic_mem_*  : icache miss request (address, valid) and block/ready return
//   dc_mem_*  : dcache request (address, rw, write block, valid) and return
//   dram_*    : granted request towards DRAM and DRAM read block/acknowledge
// ---------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4
);
  logic [ADDR_W-1:0] ic_mem_address;
  logic              ic_mem_valid;
  logic [WORD_W-1:0] ic_mem_data_out [BLOCK_WORDS];
  logic              ic_mem_ready;

  logic [ADDR_W-1:0] dc_mem_address;
  logic              dc_mem_rw;
  logic [WORD_W-1:0] dc_mem_data_write [BLOCK_WORDS];
  logic              dc_mem_valid;
  logic [WORD_W-1:0] dc_mem_data_out [BLOCK_WORDS];
  logic              dc_mem_ready;

  logic [ADDR_W-1:0] dram_address;
  logic              dram_rw;
  logic [WORD_W-1:0] dram_data_write [BLOCK_WORDS];
  logic              dram_valid;
  logic [WORD_W-1:0] dram_data_read [BLOCK_WORDS];
  logic              dram_ready;

  modport slave (
    input  ic_mem_address, ic_mem_valid,
    output ic_mem_data_out, ic_mem_ready,
    input  dc_mem_address, dc_mem_rw, dc_mem_data_write, dc_mem_valid,
    output dc_mem_data_out, dc_mem_ready,
    output dram_address, dram_rw, dram_data_write, dram_valid,
    input  dram_data_read, dram_ready
  );

  modport master (
    output ic_mem_address, ic_mem_valid,
    input  ic_mem_data_out, ic_mem_ready,
    output dc_mem_address, dc_mem_rw, dc_mem_data_write, dc_mem_valid,
    input  dc_mem_data_out, dc_mem_ready,
    input  dram_address, dram_rw, dram_data_write, dram_valid,
    output dram_data_read, dram_ready
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one DRAM block interface between the icache and dcache controllers.
// Each port latches its miss request into a pending slot; an IDLE/BUSY FSM
// grants DRAM to one slot at a time, holds the DRAM request stable until
// dram_ready, then returns the read block and a one-cycle ready pulse.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : cache_mem_arbiter_if.slave (icache, dcache and DRAM signals)
// Configuration macro:
//   CACHE_ARB_DCACHE_PRIORITY_EN - defined: dcache wins every tie;
//                                  undefined: round-robin on ties.
// All outputs are registered.
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input logic                 clock,
  input logic                 reset,
  cache_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state_r;
  logic              last_grant_r;

  // Pending slots (icache slot has no rw / write block: always a read)
  logic              ic_pend_r;
  logic [ADDR_W-1:0] ic_addr_r;
  logic              dc_pend_r;
  logic [ADDR_W-1:0] dc_addr_r;
  logic              dc_rw_r;
  logic [WORD_W-1:0] dc_wdata_r [BLOCK_WORDS];

  // Registered outputs
  logic              dram_valid_r;
  logic [ADDR_W-1:0] dram_address_r;
  logic              dram_rw_r;
  logic [WORD_W-1:0] dram_wdata_r [BLOCK_WORDS];
  logic [WORD_W-1:0] ic_data_out_r [BLOCK_WORDS];
  logic [WORD_W-1:0] dc_data_out_r [BLOCK_WORDS];
  logic              ic_ready_r;
  logic              dc_ready_r;

  logic              ic_done_s;
  logic              dc_done_s;
  logic              grant_i_s;
  logic              grant_d_s;

  // A port's transaction completes on the edge DRAM acknowledges while it owns the bus
  assign ic_done_s = (state_r == ST_BUSY_I) && bus.dram_ready;
  assign dc_done_s = (state_r == ST_BUSY_D) && bus.dram_ready;

  // Grant selection used in IDLE
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (ic_pend_r && dc_pend_r) begin
`ifdef CACHE_ARB_DCACHE_PRIORITY_EN
      grant_d_s = 1'b1;
`else
      if (last_grant_r == GRANT_D) begin
        grant_i_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
`endif
    end else if (ic_pend_r) begin
      grant_i_s = 1'b1;
    end else if (dc_pend_r) begin
      grant_d_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Pending slot capture: load when empty or on the edge the slot's own transaction completes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ic_pend_r <= 1'b0;
      ic_addr_r <= {ADDR_W{1'b0}};
      dc_pend_r <= 1'b0;
      dc_addr_r <= {ADDR_W{1'b0}};
      dc_rw_r   <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        dc_wdata_r[i] <= {WORD_W{1'b0}};
      end
    end else begin
      if (bus.ic_mem_valid && (!ic_pend_r || ic_done_s)) begin
        ic_pend_r <= 1'b1;
        ic_addr_r <= bus.ic_mem_address;
      end else if (ic_done_s) begin
        ic_pend_r <= 1'b0;
      end else begin
        ic_pend_r <= ic_pend_r;
      end

      if (bus.dc_mem_valid && (!dc_pend_r || dc_done_s)) begin
        dc_pend_r <= 1'b1;
        dc_addr_r <= bus.dc_mem_address;
        dc_rw_r   <= bus.dc_mem_rw;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
          dc_wdata_r[i] <= bus.dc_mem_data_write[i];
        end
      end else if (dc_done_s) begin
        dc_pend_r <= 1'b0;
      end else begin
        dc_pend_r <= dc_pend_r;
      end
    end
  end

  // Arbiter FSM with registered DRAM request, read-data and ready outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      last_grant_r   <= GRANT_D;
      dram_valid_r   <= 1'b0;
      dram_address_r <= {ADDR_W{1'b0}};
      dram_rw_r      <= 1'b0;
      ic_ready_r     <= 1'b0;
      dc_ready_r     <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        dram_wdata_r[i]  <= {WORD_W{1'b0}};
        ic_data_out_r[i] <= {WORD_W{1'b0}};
        dc_data_out_r[i] <= {WORD_W{1'b0}};
      end
    end else begin
      ic_ready_r <= 1'b0;
      dc_ready_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_i_s) begin
            state_r        <= ST_BUSY_I;
            last_grant_r   <= GRANT_I;
            dram_valid_r   <= 1'b1;
            dram_address_r <= ic_addr_r;
            dram_rw_r      <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              dram_wdata_r[i] <= {WORD_W{1'b0}};
            end
          end else if (grant_d_s) begin
            state_r        <= ST_BUSY_D;
            last_grant_r   <= GRANT_D;
            dram_valid_r   <= 1'b1;
            dram_address_r <= dc_addr_r;
            dram_rw_r      <= dc_rw_r;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              dram_wdata_r[i] <= dc_wdata_r[i];
            end
          end else begin
            // dram_ready seen here is stray and deliberately ignored
            dram_valid_r <= 1'b0;
          end
        end
        ST_BUSY_I: begin
          if (bus.dram_ready) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              ic_data_out_r[i] <= bus.dram_data_read[i];
              dram_wdata_r[i]  <= {WORD_W{1'b0}};
            end
            ic_ready_r     <= 1'b1;
            state_r        <= ST_IDLE;
            dram_valid_r   <= 1'b0;
            dram_address_r <= {ADDR_W{1'b0}};
            dram_rw_r      <= 1'b0;
          end else begin
            state_r <= ST_BUSY_I;
          end
        end
        ST_BUSY_D: begin
          if (bus.dram_ready) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              // a write-back leaves the dcache's last read block in place
              if (!dc_rw_r) begin
                dc_data_out_r[i] <= bus.dram_data_read[i];
              end else begin
                dc_data_out_r[i] <= dc_data_out_r[i];
              end
              dram_wdata_r[i] <= {WORD_W{1'b0}};
            end
            dc_ready_r     <= 1'b1;
            state_r        <= ST_IDLE;
            dram_valid_r   <= 1'b0;
            dram_address_r <= {ADDR_W{1'b0}};
            dram_rw_r      <= 1'b0;
          end else begin
            state_r <= ST_BUSY_D;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          dram_valid_r   <= 1'b0;
          dram_address_r <= {ADDR_W{1'b0}};
          dram_rw_r      <= 1'b0;
          for (int i = 0; i < BLOCK_WORDS; i++) begin
            dram_wdata_r[i] <= {WORD_W{1'b0}};
          end
        end
      endcase
    end
  end

  assign bus.dram_valid      = dram_valid_r;
  assign bus.dram_address    = dram_address_r;
  assign bus.dram_rw         = dram_rw_r;
  assign bus.dram_data_write = dram_wdata_r;
  assign bus.ic_mem_data_out = ic_data_out_r;
  assign bus.dc_mem_data_out = dc_data_out_r;
  assign bus.ic_mem_ready    = ic_ready_r;
  assign bus.dc_mem_ready    = dc_ready_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Self-checking bench for cache_mem_arbiter: a table of single uncontended
// transactions plus hand-written contention, stall and reset sequences.
// Expected DRAM transactions are queued in service order; a DRAM model pops
// and checks them, and a ready monitor checks the returned blocks.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  typedef struct {
    logic         port;     // 0 = icache, 1 = dcache
    logic [31:0]  addr;
    logic         rw;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           lat;
    logic [127:0] exp_data; // data_out expected on the ready pulse
  } txn_t;

  logic clock;
  logic reset;

  cache_mem_arbiter_if #(.ADDR_W(32), .WORD_W(32), .BLOCK_WORDS(4)) bus ();

  cache_mem_arbiter #(.ADDR_W(32), .WORD_W(32), .BLOCK_WORDS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  txn_t         exp_q[$];
  txn_t         done_q[$];
  logic [127:0] last_data [2];
  logic         active = 1'b0;
  logic         spurious = 1'b0;
  int           txn_count = 0;
  int           ready_count = 0;
  int           cyc = 0;
  int           last_start_cyc = 0;
  int           last_ready_cyc [2];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [127:0] ic_out();
    return {bus.ic_mem_data_out[3], bus.ic_mem_data_out[2], bus.ic_mem_data_out[1], bus.ic_mem_data_out[0]};
  endfunction

  function automatic logic [127:0] dc_out();
    return {bus.dc_mem_data_out[3], bus.dc_mem_data_out[2], bus.dc_mem_data_out[1], bus.dc_mem_data_out[0]};
  endfunction

  function automatic logic [127:0] dram_wr();
    return {bus.dram_data_write[3], bus.dram_data_write[2], bus.dram_data_write[1], bus.dram_data_write[0]};
  endfunction

  // Queue one expected transaction in service order; data_out expectation follows the port history
  task automatic push_txn(input logic port, input logic [31:0] addr, input logic rw,
                          input logic [127:0] wdata, input logic [127:0] rdata, input int lat);
    txn_t t;
    t.port = port; t.addr = addr; t.rw = rw; t.wdata = wdata; t.rdata = rdata; t.lat = lat;
    if (!rw) last_data[port] = rdata;
    t.exp_data = last_data[port];
    exp_q.push_back(t);
  endtask

  task automatic drive_dc_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) bus.dc_mem_data_write[i] = b[32*i +: 32];
  endtask

  // DRAM model: accepts a request, checks it against the scoreboard, acks after lat cycles
  initial begin
    txn_t cur;
    int   cnt;
    bus.dram_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus.dram_data_read[i] = 32'h0;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        active = 1'b0;
        bus.dram_ready = 1'b0;
      end else begin
        bus.dram_ready = spurious;
        if (bus.dram_valid && !active) begin
          txn_count++;
          last_start_cyc = cyc;
          active = 1'b1;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_dram_request actual=%h required=none", bus.dram_address);
            cur.lat = 0; cur.rdata = 128'h0;
          end else begin
            cur = exp_q.pop_front();
            chk("dram_address", {96'h0, bus.dram_address}, {96'h0, cur.addr});
            chk("dram_rw", {127'h0, bus.dram_rw}, {127'h0, cur.rw});
            if (cur.rw) chk("dram_data_write", dram_wr(), cur.wdata);
          end
          cnt = cur.lat;
        end else if (bus.dram_valid && active) begin
          chk("stable_address", {96'h0, bus.dram_address}, {96'h0, cur.addr});
          chk("stable_rw", {127'h0, bus.dram_rw}, {127'h0, cur.rw});
          if (cur.rw) chk("stable_data_write", dram_wr(), cur.wdata);
        end else if (!bus.dram_valid && active) begin
          chk("dram_valid_held", {127'h0, bus.dram_valid}, 128'h1);
          active = 1'b0;
        end
        if (active) begin
          if (cnt == 0) begin
            bus.dram_ready = 1'b1;
            for (int i = 0; i < 4; i++) bus.dram_data_read[i] = cur.rdata[32*i +: 32];
            done_q.push_back(cur);
            active = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Ready monitor: each pulse must match the oldest acknowledged transaction
  initial begin
    txn_t e;
    logic port;
    forever begin
      @(negedge clock);
      if (!reset && (bus.ic_mem_ready || bus.dc_mem_ready)) begin
        ready_count++;
        chk("ready_exclusive", {127'h0, bus.ic_mem_ready & bus.dc_mem_ready}, 128'h0);
        port = bus.dc_mem_ready;
        last_ready_cyc[port] = cyc;
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready actual=port%0d required=none", port);
        end else begin
          e = done_q.pop_front();
          chk("ready_port", {127'h0, port}, {127'h0, e.port});
          chk("data_out", port ? dc_out() : ic_out(), e.exp_data);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    bus.ic_mem_valid = 1'b0;
    bus.dc_mem_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    last_data[0] = 128'h0;
    last_data[1] = 128'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && (exp_q.size() != 0 || done_q.size() != 0 || active)) begin
      @(negedge clock);
      n++;
    end
    chk(name, {127'h0, (n < budget)}, 128'h1);
    repeat (2) @(negedge clock);
  endtask

  txn_t vecs [7];

  initial begin
    int   n;
    int   base;
    logic seen;
    int   rc;

    // {port, addr, rw, wdata, rdata, lat, expected data_out}
    vecs[0] = '{1'b0, 32'h0000_0040, 1'b0, 128'h0, {32'd4, 32'd3, 32'd2, 32'd1}, 3, {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[1] = '{1'b1, 32'h0000_0080, 1'b0, 128'h0, 128'h1111_0004_1111_0003_1111_0002_1111_0001, 0,
                128'h1111_0004_1111_0003_1111_0002_1111_0001};
    vecs[2] = '{1'b1, 32'h0000_0084, 1'b1, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 128'h5555_5555_5555_5555_5555_5555_5555_5555, 1,
                128'h1111_0004_1111_0003_1111_0002_1111_0001};
    vecs[3] = '{1'b0, 32'h0000_1000, 1'b0, 128'h0, 128'hA5A5_A5A5_0000_0000_FFFF_FFFF_1234_5678, 2,
                128'hA5A5_A5A5_0000_0000_FFFF_FFFF_1234_5678};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 128'h0, 128'h8000_0000_0000_0001_7FFF_FFFF_FFFF_FFFE, 5,
                128'h8000_0000_0000_0001_7FFF_FFFF_FFFF_FFFE};
    vecs[5] = '{1'b0, 32'hFFFF_FFF0, 1'b0, 128'h0, {128{1'b1}}, 0, {128{1'b1}}};
    vecs[6] = '{1'b1, 32'h0000_0000, 1'b1, 128'h0F0F_0F0F_F0F0_F0F0_3333_3333_CCCC_CCCC, 128'h0, 0,
                128'h8000_0000_0000_0001_7FFF_FFFF_FFFF_FFFE};

    bus.ic_mem_address = 32'h0;
    bus.ic_mem_valid   = 1'b0;
    bus.dc_mem_address = 32'h0;
    bus.dc_mem_rw      = 1'b0;
    bus.dc_mem_valid   = 1'b0;
    drive_dc_block(128'h0);
    last_ready_cyc[0] = 0;
    last_ready_cyc[1] = 0;
    reset = 1'b1;
    #1;
    // Reset state: every output 0
    chk("rst_dram_valid", {127'h0, bus.dram_valid}, 128'h0);
    chk("rst_dram_address", {96'h0, bus.dram_address}, 128'h0);
    chk("rst_dram_rw", {127'h0, bus.dram_rw}, 128'h0);
    chk("rst_dram_data_write", dram_wr(), 128'h0);
    chk("rst_ic_ready", {127'h0, bus.ic_mem_ready}, 128'h0);
    chk("rst_dc_ready", {127'h0, bus.dc_mem_ready}, 128'h0);
    chk("rst_ic_data_out", ic_out(), 128'h0);
    chk("rst_dc_data_out", dc_out(), 128'h0);
    apply_reset();

    // Table: uncontended single transactions
    for (int v = 0; v < 7; v++) begin
      push_txn(vecs[v].port, vecs[v].addr, vecs[v].rw, vecs[v].wdata, vecs[v].rdata, vecs[v].lat);
      @(negedge clock);
      if (vecs[v].port) begin
        bus.dc_mem_address = vecs[v].addr;
        bus.dc_mem_rw      = vecs[v].rw;
        drive_dc_block(vecs[v].wdata);
        bus.dc_mem_valid   = 1'b1;
      end else begin
        bus.ic_mem_address = vecs[v].addr;
        bus.ic_mem_valid   = 1'b1;
      end
      @(negedge clock);
      bus.ic_mem_valid = 1'b0;
      bus.dc_mem_valid = 1'b0;
      n = 0;
      seen = 1'b0;
      while (n < 100 && !seen) begin
        @(negedge clock);
        n++;
        seen = vecs[v].port ? bus.dc_mem_ready : bus.ic_mem_ready;
      end
      chk("vec_latency", n, vecs[v].lat + 2);
      chk("vec_data_out", vecs[v].port ? dc_out() : ic_out(), vecs[v].exp_data);
      chk("vec_other_ready", {127'h0, vecs[v].port ? bus.ic_mem_ready : bus.dc_mem_ready}, 128'h0);
      @(negedge clock);
      chk("vec_ready_width", {127'h0, bus.ic_mem_ready | bus.dc_mem_ready}, 128'h0);
    end
    wait_drain("table_drain", 50);

    // dram_ready while IDLE is ignored
    rc = ready_count;
    spurious = 1'b1;
    repeat (2) @(negedge clock);
    spurious = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_ready_ignored", rc, ready_count);
    chk("idle_dram_valid", {127'h0, bus.dram_valid}, 128'h0);

    // Simultaneous pulses out of reset
    apply_reset();
`ifdef CACHE_ARB_DCACHE_PRIORITY_EN
    push_txn(1'b1, 32'h200, 1'b1, 128'h2222_2222_3333_3333_4444_4444_5555_5555, 128'h0, 2);
    push_txn(1'b0, 32'h100, 1'b0, 128'h0, 128'h0000_0100_0000_0200_0000_0300_0000_0400, 2);
`else
    push_txn(1'b0, 32'h100, 1'b0, 128'h0, 128'h0000_0100_0000_0200_0000_0300_0000_0400, 2);
    push_txn(1'b1, 32'h200, 1'b1, 128'h2222_2222_3333_3333_4444_4444_5555_5555, 128'h0, 2);
`endif
    @(negedge clock);
    bus.ic_mem_address = 32'h100;
    bus.ic_mem_valid   = 1'b1;
    bus.dc_mem_address = 32'h200;
    bus.dc_mem_rw      = 1'b1;
    drive_dc_block(128'h2222_2222_3333_3333_4444_4444_5555_5555);
    bus.dc_mem_valid   = 1'b1;
    @(negedge clock);
    bus.ic_mem_valid = 1'b0;
    bus.dc_mem_valid = 1'b0;
    wait_drain("simul_drain", 100);
    chk("simul_dc_data_out", dc_out(), 128'h0);

    // Saturation: both valids held high so each completion reloads its slot
    apply_reset();
    for (int k = 0; k < 6; k++) begin
`ifdef CACHE_ARB_DCACHE_PRIORITY_EN
      if (k < 5) push_txn(1'b1, 32'h400, 1'b0, 128'h0, {96'h0, 32'hD0 + k}, 2);
      else       push_txn(1'b0, 32'h300, 1'b0, 128'h0, {96'h0, 32'hA0 + k}, 2);
`else
      if (k % 2 == 0) push_txn(1'b0, 32'h300, 1'b0, 128'h0, {96'h0, 32'hA0 + k}, 2);
      else            push_txn(1'b1, 32'h400, 1'b0, 128'h0, {96'h0, 32'hD0 + k}, 2);
`endif
    end
    base = txn_count;
    @(negedge clock);
    bus.ic_mem_address = 32'h300;
    bus.dc_mem_address = 32'h400;
    bus.dc_mem_rw      = 1'b0;
    bus.ic_mem_valid   = 1'b1;
    bus.dc_mem_valid   = 1'b1;
    n = 0;
    while (n < 200 && txn_count < base + 5) begin
      @(negedge clock);
      n++;
    end
    bus.ic_mem_valid = 1'b0;
    bus.dc_mem_valid = 1'b0;
    chk("sat_reach_fifth", {127'h0, (n < 200)}, 128'h1);
    wait_drain("sat_drain", 100);
    chk("sat_txn_total", txn_count - base, 6);

    // Long stall with a dcache pulse arriving mid-transaction
    apply_reset();
    push_txn(1'b0, 32'h500, 1'b0, 128'h0, 128'h0505_0505_0505_0505_0505_0505_0505_0505, 10);
    push_txn(1'b1, 32'h600, 1'b0, 128'h0, 128'h0606_0606_0606_0606_0606_0606_0606_0606, 1);
    @(negedge clock);
    bus.ic_mem_address = 32'h500;
    bus.ic_mem_valid   = 1'b1;
    @(negedge clock);
    bus.ic_mem_valid = 1'b0;
    repeat (4) @(negedge clock);
    bus.dc_mem_address = 32'h600;
    bus.dc_mem_rw      = 1'b0;
    bus.dc_mem_valid   = 1'b1;
    @(negedge clock);
    bus.dc_mem_valid = 1'b0;
    wait_drain("stall_drain", 100);
    chk("late_grant_gap", last_start_cyc - last_ready_cyc[0], 1);

    // Asynchronous reset in BUSY_D with the icache slot also pending
    apply_reset();
    push_txn(1'b1, 32'h700, 1'b1, 128'h7777_7777_7777_7777_7777_7777_7777_7777, 128'h0, 20);
    @(negedge clock);
    bus.dc_mem_address = 32'h700;
    bus.dc_mem_rw      = 1'b1;
    drive_dc_block(128'h7777_7777_7777_7777_7777_7777_7777_7777);
    bus.dc_mem_valid   = 1'b1;
    @(negedge clock);
    bus.dc_mem_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("busy_before_reset", {127'h0, bus.dram_valid}, 128'h1);
    bus.ic_mem_address = 32'h900;
    bus.ic_mem_valid   = 1'b1;
    @(negedge clock);
    bus.ic_mem_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_dram_valid", {127'h0, bus.dram_valid}, 128'h0);
    chk("async_dram_address", {96'h0, bus.dram_address}, 128'h0);
    exp_q.delete();
    done_q.delete();
    last_data[0] = 128'h0;
    last_data[1] = 128'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("post_reset_idle", {127'h0, bus.dram_valid}, 128'h0);
    end
    chk("post_reset_dc_data_out", dc_out(), 128'h0);
    push_txn(1'b0, 32'h800, 1'b0, 128'h0, 128'h0808_0808_0808_0808_0808_0808_0808_0808, 1);
    @(negedge clock);
    bus.ic_mem_address = 32'h800;
    bus.ic_mem_valid   = 1'b1;
    @(negedge clock);
    bus.ic_mem_valid = 1'b0;
    wait_drain("post_reset_drain", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
